// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width,
// system clock rate and a modular-increment helper for the round-robin pointer.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_W = 8;
    localparam int CLK_FREQ_HZ = 100_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_t;

    // Explicit compare so the pointer wraps correctly for non-power-of-2 counts.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority encoder: the first asserted request at or after rr_ptr
// (mod NUM_REQ) wins. Purely combinational.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int              pos;
    logic [PTR_W-1:0] pos_idx;

    // Scan from the farthest offset down so the closest requester is written last.
    always_comb begin
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = PTR_W'(pos);
            if (req[pos_idx]) begin
                idx = pos_idx;
                any = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign onehot[gi] = any && (idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with packet lock so a multi-byte message goes out contiguously.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int HOLD_TIMEOUT = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);

    arb_state_t          state_reg;
    logic [PTR_W-1:0]    rr_ptr_reg;
    logic [PTR_W-1:0]    win_idx_reg;
    logic                lock_reg;
    logic [CNT_W-1:0]    hold_cnt_reg;
    logic [NUM_REQ-1:0]  ack_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic                tx_send_reg;
    logic [DATA_W-1:0]   tx_data_reg;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign rr_ptr_next = PTR_W'(wrap_inc(int'(win_idx_reg), NUM_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            win_idx_reg  <= '0;
            lock_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            ack_reg      <= '0;
            grant_reg    <= '0;
            tx_send_reg  <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            ack_reg     <= '0;
            tx_send_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (tx_ready && pick_any) begin
                        grant_reg   <= pick_onehot;
                        win_idx_reg <= pick_idx;
                        tx_data_reg <= data_arr[pick_idx];
                        lock_reg    <= ~req_last[pick_idx];
                        ack_reg     <= pick_onehot;
                        tx_send_reg <= 1'b1;
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_reg <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        if (lock_reg) begin
                            hold_cnt_reg <= '0;
                            state_reg    <= ST_HOLD;
                        end else begin
                            grant_reg  <= '0;
                            rr_ptr_reg <= rr_ptr_next;
                            state_reg  <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only the lock owner may continue; everyone else waits.
                    if (req[win_idx_reg]) begin
                        tx_data_reg  <= data_arr[win_idx_reg];
                        lock_reg     <= ~req_last[win_idx_reg];
                        ack_reg      <= grant_reg;
                        tx_send_reg  <= 1'b1;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_SEND;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        grant_reg  <= '0;
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= ST_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_reg;
    assign grant   = grant_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign tx_send = tx_send_reg;
    assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level transmitter stand-in
// that drops ready one cycle after a send and records every byte it accepts.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int HOLD_TO = 50;
    localparam int FRAME   = 20;
    localparam int BUDGET  = 500;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      tx_send;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;

    logic                      model_ready;
    int                        model_cnt;
    logic                      force_low = 1'b0;
    logic [DATA_W-1:0]         sent_q[$];
    logic                      msg_active = 1'b0;
    int                        g0_viol;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .HOLD_TIMEOUT (HOLD_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    assign tx_ready = model_ready && !force_low;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_ready <= 1'b1;
            model_cnt   <= 0;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_ready <= 1'b1;
        end else if (tx_send && tx_ready) begin
            model_ready <= 1'b0;
            model_cnt   <= FRAME;
            sent_q.push_back(tx_data);
        end
    end

    always @(posedge clk) begin
        if (rst)                       g0_viol <= 0;
        else if (msg_active && grant[0]) g0_viol <= g0_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input logic [7:0] exp_data);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            tick();
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ack_seen"}, 32'(ok), 32'd1);
        $display("txn %s: ack=%b grant=%b tx_send=%b tx_data=%h", tag, ack, grant, tx_send, tx_data);
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
        check({tag, "_send"}, 32'(tx_send), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
        check({tag, "_grant_free"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_state(input string tag, input arb_state_t s);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            tick();
            if (dut.state_reg == s) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_state_reached"}, 32'(ok), 32'd1);
    endtask

    task automatic check_q(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic set_byte(input int i, input logic [7:0] d, input logic last);
        req_data[i*DATA_W +: DATA_W] = d;
        req_last[i] = last;
        req[i] = 1'b1;
    endtask

    initial begin
        int n;
        int early_ack;
        int viol;

        // Reset state
        tick(); tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_send", 32'(tx_send), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single byte from requester 0
        set_byte(0, 8'h41, 1'b1);
        wait_ack("t1", 4'b0001, 8'h41);
        check("t1_grant", 32'(grant), 32'b0001);
        req[0] = 1'b0;
        tick();
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_send_pulse", 32'(tx_send), 32'd0);
        wait_idle("t1");
        check("t1_rr_ptr", 32'(dut.rr_ptr_reg), 32'd1);
        check("t1_q_size", 32'(sent_q.size()), 32'd1);
        check_q("t1_line", 8'h41);

        // 2: all four held, round-robin from pointer 0 with wrap
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("t2_%0d", k), 4'(1 << (k % 4)), 8'(8'h10 + (k % 4)));
        end
        req = '0;
        wait_idle("t2");
        check("t2_q_size", 32'(sent_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) check_q($sformatf("t2_line_%0d", k), 8'(8'h10 + (k % 4)));

        // 3: locked message from requester 2 while requester 0 waits (pointer is 1)
        msg_active = 1'b1;
        set_byte(0, 8'h55, 1'b1);
        set_byte(2, 8'h48, 1'b0);
        wait_ack("t3_H", 4'b0100, 8'h48);
        set_byte(2, 8'h49, 1'b0);
        wait_ack("t3_I", 4'b0100, 8'h49);
        set_byte(2, 8'h0A, 1'b1);
        wait_ack("t3_nl", 4'b0100, 8'h0A);
        req[2] = 1'b0;
        wait_idle("t3_msg");
        viol = g0_viol;
        msg_active = 1'b0;
        check("t3_grant0_during_msg", 32'(viol), 32'd0);
        wait_ack("t3_r0", 4'b0001, 8'h55);
        req[0] = 1'b0;
        wait_idle("t3");
        check_q("t3_line_0", 8'h48);
        check_q("t3_line_1", 8'h49);
        check_q("t3_line_2", 8'h0A);
        check_q("t3_line_3", 8'h55);

        // 4: locked grant times out; pending requester 3 is served next
        set_byte(1, 8'h77, 1'b0);
        wait_ack("t4_r1", 4'b0010, 8'h77);
        req[1] = 1'b0;
        set_byte(3, 8'h33, 1'b1);
        wait_state("t4_hold", ST_HOLD);
        n = 0;
        early_ack = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            if (ack != '0) early_ack++;
            if (grant == '0) break;
        end
        check("t4_release_cycles", 32'(n), 32'd50);
        check("t4_no_ack_in_hold", 32'(early_ack), 32'd0);
        wait_ack("t4_r3", 4'b1000, 8'h33);
        req[3] = 1'b0;
        wait_idle("t4");

        // 5: reset during WAIT_DONE, then arbitration restarts at pointer 0
        set_byte(1, 8'h21, 1'b1);
        wait_ack("t5_r1", 4'b0010, 8'h21);
        req[1] = 1'b0;
        wait_idle("t5_pre");
        check("t5_ptr_before", 32'(dut.rr_ptr_reg), 32'd2);
        set_byte(2, 8'h99, 1'b1);
        wait_ack("t5_r2", 4'b0100, 8'h99);
        req[2] = 1'b0;
        wait_state("t5_wait_done", ST_WAIT_DONE);
        #2;
        rst = 1'b1;
        #1;
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_send", 32'(tx_send), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_data", 32'(tx_data), 32'd0);
        tick(); tick();
        rst = 1'b0;
        set_byte(1, 8'h61, 1'b1);
        set_byte(2, 8'h62, 1'b1);
        wait_ack("t5_after", 4'b0010, 8'h61);
        req = '0;
        wait_idle("t5");

        // 6: transmitter not ready blocks arbitration
        force_low = 1'b1;
        set_byte(0, 8'h5A, 1'b1);
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ack != '0 || tx_send) viol++;
        end
        check("t6_blocked", 32'(viol), 32'd0);
        force_low = 1'b0;
        wait_ack("t6_r0", 4'b0001, 8'h5A);
        req[0] = 1'b0;
        wait_idle("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
